apb_timer_req_arb: RTL

- Round-robin APB master that shares the timer peripheral bank (TIM_NUM 32-bit timers, 3 registers each) between REQ_NUM on-chip requesters.
- Each requester posts single register read/write commands; the arbiter grants one at a time, runs a two-phase APB transfer and returns data and error status to the granted requester.
- Sits between the requesters (core-side sequencers, DMA, debug) and the timer bank's APB slave port.

---
 rtl/apb_timer_req_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apb_timer_req_arb.sv
// Round-robin APB master sharing the timer register bank among REQ_NUM requesters.
// It runs one single-register transfer at a time and routes the response to the owning requester.
module apb_timer_req_arb #(
    parameter int                        REQ_NUM        = 4,
    parameter int                        TIM_NUM        = 2,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        TIMEOUT        = 16,
    localparam int                       TIW            = (TIM_NUM > 1) ? $clog2(TIM_NUM) : 1
) (
    input  logic                              pclk_i,
    input  logic                              presetn_i,
    input  logic [REQ_NUM-1:0]                req_valid_i,
    output logic [REQ_NUM-1:0]                req_ready_o,
    input  logic [REQ_NUM-1:0]                req_write_i,
    input  logic [REQ_NUM*TIW-1:0]            req_tim_i,
    input  logic [REQ_NUM*2-1:0]              req_reg_i,
    input  logic [REQ_NUM*APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic [REQ_NUM-1:0]                rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0]         paddr_o,
    output logic [APB_DATA_WIDTH-1:0]         pwdata_o,
    output logic                              pwrite_o,
    output logic                              psel_o,
    output logic                              penable_o,
    input  logic [APB_DATA_WIDTH-1:0]         prdata_i,
    input  logic                              pready_i,
    input  logic                              pslverr_i,
    output logic                              busy_o
);

    localparam int PW = $clog2(REQ_NUM);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               ptr_q;
    logic                        write_q;
    logic [TIW-1:0]              tim_q;
    logic [1:0]                  reg_q;
    logic [APB_DATA_WIDTH-1:0]   wdata_q;
    logic [CW-1:0]               wait_q;
    logic [APB_DATA_WIDTH-1:0]   rdata_q;
    logic                        err_q;

    logic [PW:0]                 pick_res;
    logic                        gnt_any;
    logic [PW-1:0]               gnt_idx;
    logic [1:0]                  gnt_reg;
    logic                        wait_expire;

    // First valid requester after the pointer, wrapping; MSB flags that one was found.
    function automatic logic [PW:0] pick_next(input logic [REQ_NUM-1:0] v,
                                              input logic [PW-1:0]      p);
        int c;
        pick_next = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            c = (int'(p) + k) % REQ_NUM;
            if (!pick_next[PW] && v[c]) begin
                pick_next = {1'b1, PW'(c)};
            end
        end
    endfunction

    assign pick_res    = pick_next(req_valid_i, ptr_q);
    assign gnt_any     = pick_res[PW];
    assign gnt_idx     = pick_res[PW-1:0];
    assign gnt_reg     = req_reg_i[int'(gnt_idx)*2 +: 2];
    assign wait_expire = (TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1);

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = (gnt_reg == 2'd3) ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i || wait_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            IDLE:    if (gnt_any) req_ready_o = REQ_NUM'(1) << gnt_idx;
            SETUP:   psel_o = 1'b1;
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            RESP: begin
                rsp_valid_o = REQ_NUM'(1) << ptr_q;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    // Command latch, wait counter and response capture; pointer doubles as the owner index.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            ptr_q   <= PW'(REQ_NUM - 1);
            write_q <= 1'b0;
            tim_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        ptr_q   <= gnt_idx;
                        write_q <= req_write_i[gnt_idx];
                        tim_q   <= req_tim_i[int'(gnt_idx)*TIW +: TIW];
                        reg_q   <= gnt_reg;
                        wdata_q <= req_wdata_i[int'(gnt_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        wait_q  <= '0;
                        rdata_q <= '0;
                        err_q   <= (gnt_reg == 2'd3);
                    end
                end
                ACCESS: begin
                    if (pready_i) begin
                        rdata_q <= write_q ? '0 : prdata_i;
                        err_q   <= pslverr_i;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (wait_expire) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign paddr_o  = BASE_ADDR + APB_ADDR_WIDTH'({tim_q, reg_q, 2'b00});
    assign pwdata_o = wdata_q;
    assign pwrite_o = write_q;

endmodule
